// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: default width,
// FSM state encoding and two's-complement magnitude helpers.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Two's-complement negation of a WIDTH-bit value.
    function automatic logic [DIV_WIDTH-1:0] neg_w(input logic [DIV_WIDTH-1:0] v);
        return ~v + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation of a 2*WIDTH-bit value.
    function automatic logic [2*DIV_WIDTH-1:0] neg_dw(input logic [2*DIV_WIDTH-1:0] v);
        return ~v + {{(2*DIV_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Unsigned magnitude of a signed WIDTH-bit value (the most negative
    // value maps to 2^(WIDTH-1), which still fits unsigned).
    function automatic logic [DIV_WIDTH-1:0] abs_w(input logic [DIV_WIDTH-1:0] v);
        return v[DIV_WIDTH-1] ? neg_w(v) : v;
    endfunction

    // Unsigned magnitude of a signed 2*WIDTH-bit value.
    function automatic logic [2*DIV_WIDTH-1:0] abs_dw(input logic [2*DIV_WIDTH-1:0] v);
        return v[2*DIV_WIDTH-1] ? neg_dw(v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step: shift the next dividend bit into the
// partial remainder and trial-subtract the divisor magnitude.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] diff_s;

    // Trial subtraction; rem_in is always below dsr, so shifted_s stays below
    // 2*dsr and the top bit of the difference is a clean borrow flag.
    always_comb begin
        shifted_s = {rem_in, dvd_bit};
        diff_s    = shifted_s - {2'b00, dsr};
        q_bit     = ~diff_s[WIDTH+1];
        if (q_bit) begin
            rem_out = diff_s[WIDTH:0];
        end else begin
            rem_out = shifted_s[WIDTH:0];
        end
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per slow_clk, with start/busy/done handshake and
// divide-by-zero / overflow flags.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               slow_clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_zero,
    output logic               overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_MAG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dsr_r;
    logic [WIDTH-1:0] dvd_lo_r;
    logic             sign_a_r;
    logic             sign_b_r;
    logic             dz_r;
    logic             pre_ovf_r;

    logic [2*WIDTH-1:0] dvd_abs_s;
    logic [WIDTH-1:0]   dsr_abs_s;
    logic               dz_s;
    logic               pre_ovf_s;
    logic [WIDTH:0]     step_rem_s;
    logic               step_q_s;
    logic               neg_q_s;
    logic               post_ovf_s;

    // Operand magnitudes and early-exit conditions evaluated at accept time.
    always_comb begin
        dvd_abs_s = abs_dw(dividend);
        dsr_abs_s = abs_w(divisor);
        dz_s      = (divisor == {WIDTH{1'b0}});
        if (dz_s) begin
            pre_ovf_s = 1'b0;
        end else begin
            // Upper half >= divisor means the quotient needs more than WIDTH bits.
            pre_ovf_s = (dvd_abs_s[2*WIDTH-1:WIDTH] >= dsr_abs_s);
        end
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .dvd_bit (quo_r[WIDTH-1]),
        .dsr     (dsr_r),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // Sign of the final quotient and range check of its magnitude.
    always_comb begin
        neg_q_s = (sign_a_r ^ sign_b_r) && (quo_r != {WIDTH{1'b0}});
        if (neg_q_s) begin
            post_ovf_s = (quo_r > MIN_MAG);
        end else begin
            post_ovf_s = (quo_r > MAX_POS);
        end
    end

    // Divider FSM: accept, iterate WIDTH restoring steps, then sign-fix and publish.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= {CW{1'b0}};
            rem_r     <= {(WIDTH+1){1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            dsr_r     <= {WIDTH{1'b0}};
            dvd_lo_r  <= {WIDTH{1'b0}};
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            dz_r      <= 1'b0;
            pre_ovf_r <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= {WIDTH{1'b0}};
            remainder <= {WIDTH{1'b0}};
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        rem_r     <= {1'b0, dvd_abs_s[2*WIDTH-1:WIDTH]};
                        quo_r     <= dvd_abs_s[WIDTH-1:0];
                        dsr_r     <= dsr_abs_s;
                        dvd_lo_r  <= dividend[WIDTH-1:0];
                        sign_a_r  <= dividend[2*WIDTH-1];
                        sign_b_r  <= divisor[WIDTH-1];
                        dz_r      <= dz_s;
                        pre_ovf_r <= pre_ovf_s;
                        cnt_r     <= {CW{1'b0}};
                        busy      <= 1'b1;
                        if (dz_s || pre_ovf_s) begin
                            state_r <= S_FIN;
                        end else begin
                            state_r <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_r <= step_rem_s;
                    quo_r <= {quo_r[WIDTH-2:0], step_q_s};
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_r <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (dz_r) begin
                        div_zero  <= 1'b1;
                        overflow  <= 1'b0;
                        quotient  <= {WIDTH{1'b1}};
                        remainder <= dvd_lo_r;
                    end else if (pre_ovf_r || post_ovf_s) begin
                        div_zero  <= 1'b0;
                        overflow  <= 1'b1;
                        quotient  <= MIN_MAG;
                        remainder <= {WIDTH{1'b0}};
                    end else begin
                        div_zero  <= 1'b0;
                        overflow  <= 1'b0;
                        quotient  <= neg_q_s ? neg_w(quo_r) : quo_r;
                        remainder <= sign_a_r ? neg_w(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
